// File: rtl/mem_wb_writeback_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback_pkg
// Shared constants for the MEM/WB writeback stage:
//   - bit positions inside the writeback control bus ({RegWrite, MemtoReg})
//   - load-size encodings carried in load_type[1:0]
//   - halt-retirement FSM state encodings
// -----------------------------------------------------------------------------
package mem_wb_writeback_pkg;

    // Writeback control bus bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // load_type[1:0] size encodings; load_type[2] = 1 selects zero extension
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b11;

    // Halt-retirement FSM states
    localparam logic [1:0] ST_RUN       = 2'b00;
    localparam logic [1:0] ST_HALT_PEND = 2'b01;
    localparam logic [1:0] ST_HALTED    = 2'b10;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback_if
// Bundles the MEM-stage inputs, the debug handshake and the register-file
// write port of the writeback stage.
//   master : the MEM stage / debug unit side (drives in_*, debug_resume)
//   slave  : the writeback stage (drives RegWrite, write_register,
//            write_data, halted, retired_count)
// Handshake: in_valid qualifies every in_* field on the sampling edge; there
// is no back-pressure, so a valid beat is consumed on the edge it is seen
// unless the halt FSM is outside RUN, in which case it is dropped.
// -----------------------------------------------------------------------------
interface mem_wb_writeback_if #(
    parameter int len_data   = 32,
    parameter int num_bits   = 5,
    parameter int len_wb_bus = 2,
    parameter int len_cnt    = 32
);
    logic                  in_valid;
    logic [len_data-1:0]   in_alu_result;
    logic [len_data-1:0]   in_mem_data;
    logic [num_bits-1:0]   in_write_register;
    logic [len_wb_bus-1:0] in_writeBack_bus;
    logic [2:0]            in_load_type;
    logic                  in_link;
    logic [len_data-1:0]   in_pc_link;
    logic                  in_halt_flag_d;
    logic                  debug_resume;

    logic                  RegWrite;
    logic [num_bits-1:0]   write_register;
    logic [len_data-1:0]   write_data;
    logic                  halted;
    logic [len_cnt-1:0]    retired_count;

    modport master (
        output in_valid, in_alu_result, in_mem_data, in_write_register,
               in_writeBack_bus, in_load_type, in_link, in_pc_link,
               in_halt_flag_d, debug_resume,
        input  RegWrite, write_register, write_data, halted, retired_count
    );

    modport slave (
        input  in_valid, in_alu_result, in_mem_data, in_write_register,
               in_writeBack_bus, in_load_type, in_link, in_pc_link,
               in_halt_flag_d, debug_resume,
        output RegWrite, write_register, write_data, halted, retired_count
    );
endinterface

// File: rtl/mem_wb_writeback_load_extender.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback_load_extender
// Purely combinational load-width extraction with sign/zero extension.
// Memory is big-endian: byte offset 0 is the most significant lane.
// Ports:
//   word      in   raw 32-bit word read from data memory
//   offset    in   byte offset (address bits 1:0)
//   load_type in   bit2 unsigned, bits1:0 size (00 byte, 01 half, 11 word)
//   ext_data  out  extracted and extended value
// -----------------------------------------------------------------------------
module mem_wb_writeback_load_extender
    import mem_wb_writeback_pkg::*;
#(
    parameter int len_data = 32
) (
    input  logic [len_data-1:0] word,
    input  logic [1:0]          offset,
    input  logic [2:0]          load_type,
    output logic [len_data-1:0] ext_data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        is_unsigned;

    assign is_unsigned = load_type[2];

    always_comb begin
        byte_lane = 8'h00;
        case (offset)
            2'd0:    byte_lane = word[31:24];
            2'd1:    byte_lane = word[23:16];
            2'd2:    byte_lane = word[15:8];
            default: byte_lane = word[7:0];
        endcase
        // offset[0] is deliberately ignored: a misaligned half reads the
        // aligned half that contains it, no exception is raised.
        half_lane = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        ext_data = word;
        case (load_type[1:0])
            LD_BYTE: ext_data = {{(len_data-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
            LD_HALF: ext_data = {{(len_data-16){half_lane[15] & ~is_unsigned}}, half_lane};
            default: ext_data = word;   // LD_WORD (and unused 2'b10)
        endcase
    end
endmodule

// File: rtl/mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback
// MEM/WB latch and writeback logic of the MIPS core. All state updates on the
// falling edge of clk so the decode stage can write the register file in the
// following half cycle.
// Ports:
//   clk        in   system clock, state updates on negedge
//   reset      in   synchronous active-high reset, sampled on negedge
//   bus        slave modport of mem_wb_writeback_if (MEM inputs, debug
//              resume, register-file write port, halted, retired_count)
//   state_dbg  out  current halt-retirement FSM state
// Build option: define RETIRE_COUNT_EN to build the retired-instruction
// counter; otherwise retired_count is tied to 0.
// -----------------------------------------------------------------------------
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int len_data   = 32,
    parameter int num_bits   = 5,
    parameter int len_wb_bus = 2,
    parameter int len_cnt    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_wb_writeback_if.slave      bus,
    output logic [1:0]             state_dbg
);
    logic [1:0]          state_q;
    logic [1:0]          state_next;
    logic                reg_write_q;
    logic [num_bits-1:0] write_register_q;
    logic [len_data-1:0] write_data_q;
    logic [len_data-1:0] load_data;
    logic [len_data-1:0] wb_data;
    logic                accept;
    logic                wants_write;

    mem_wb_writeback_load_extender #(.len_data(len_data)) u_load_extender (
        .word      (bus.in_mem_data),
        .offset    (bus.in_alu_result[1:0]),
        .load_type (bus.in_load_type),
        .ext_data  (load_data)
    );

    // A beat is only consumed while running; HALT_PEND and HALTED drop it.
    assign accept = (state_q == ST_RUN) && bus.in_valid;

    // The halt slot retires (counts) but never writes; $0 is never written.
    assign wants_write = bus.in_writeBack_bus[WB_REGWRITE]
                       && (bus.in_write_register != '0)
                       && !bus.in_halt_flag_d;

    always_comb begin
        wb_data = bus.in_alu_result;
        if (bus.in_link)
            wb_data = bus.in_pc_link;
        else if (bus.in_writeBack_bus[WB_MEMTOREG])
            wb_data = load_data;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_RUN:       if (bus.in_valid && bus.in_halt_flag_d) state_next = ST_HALT_PEND;
            ST_HALT_PEND: state_next = ST_HALTED;
            // Only resume is looked at here, so a coincident halt flag is
            // not re-sampled and resume wins.
            ST_HALTED:    if (bus.debug_resume) state_next = ST_RUN;
            default:      state_next = ST_RUN;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            state_q <= state_next;
            if (accept) begin
                reg_write_q      <= wants_write;
                write_register_q <= bus.in_write_register;
                write_data_q     <= wb_data;
            end else begin
                // Bubbles and halted cycles keep index/data for debug visibility.
                reg_write_q <= 1'b0;
            end
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [len_cnt-1:0] retired_q;

    // Wraps silently; frozen outside RUN because accept requires RUN.
    always_ff @(negedge clk) begin
        if (reset)
            retired_q <= '0;
        else if (accept)
            retired_q <= retired_q + 1'b1;
    end

    assign bus.retired_count = retired_q;
`else
    assign bus.retired_count = '0;
`endif

    assign bus.RegWrite       = reg_write_q;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;
    assign bus.halted         = (state_q == ST_HALTED);
    assign state_dbg          = state_q;
endmodule
